// File: rtl/fifo_flags.sv
// Parametrised synchronous FIFO with optional first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, flush and sticky error flags.
module fifo_flags #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned FWFT     = 0,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     clr_err,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt, rd_ptr_nxt, cnt_nxt;
    logic             rd_acc, wr_acc;
    logic             ovf_nxt, unf_nxt;
    logic [AW-1:0]    wr_idx, rd_idx;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    // Acceptance, next pointers and next error state; flush masks both requests.
    always_comb begin
        rd_acc     = 1'b0;
        wr_acc     = 1'b0;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        cnt_nxt    = '0;
        ovf_nxt    = overflow && !clr_err;
        unf_nxt    = underflow && !clr_err;
        if (!flush) begin
            rd_acc = rd && !empty;
            wr_acc = wr && (!full || rd_acc);
            if (wr && !wr_acc) ovf_nxt = 1'b1;
            if (rd && !rd_acc) unf_nxt = 1'b1;
            wr_ptr_nxt = wr_ptr + PW'(wr_acc);
            rd_ptr_nxt = rd_ptr + PW'(rd_acc);
        end else begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end
        cnt_nxt = wr_ptr_nxt - rd_ptr_nxt;
    end

    // Pointers, status and error flags; status is registered from next-state pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= (AF_LEVEL == 0);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= cnt_nxt;
            empty        <= (cnt_nxt == '0);
            full         <= (cnt_nxt == PW'(DEPTH));
            almost_empty <= (32'(cnt_nxt) <= AE_LEVEL);
            almost_full  <= (32'(cnt_nxt) >= AF_LEVEL);
            overflow     <= ovf_nxt;
            underflow    <= unf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_idx] <= din;
    end

    // Show-ahead presents the head word directly; standard mode registers it on read.
    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = mem[rd_idx];
        end else begin : g_std
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)        dout <= '0;
                else if (flush)  dout <= '0;
                else if (rd_acc) dout <= mem[rd_idx];
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_flags.sv
// Directed self-checking bench for fifo_flags: a standard-read instance and a
// first-word-fall-through instance sharing clock and reset.
module tb_fifo_flags;

    localparam int unsigned W = 32;
    localparam int unsigned D = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          flush = 1'b0, clr_err = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [W-1:0]  din = '0;
    logic [W-1:0]  dout;
    logic          empty, full, almost_empty, almost_full, overflow, underflow;
    logic [5:0]    count;

    logic          f_flush = 1'b0, f_clr_err = 1'b0, f_wr = 1'b0, f_rd = 1'b0;
    logic [W-1:0]  f_din = '0;
    logic [W-1:0]  f_dout;
    logic          f_empty, f_full, f_almost_empty, f_almost_full, f_overflow, f_underflow;
    logic [5:0]    f_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_flags #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_LEVEL(30), .AE_LEVEL(2)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err), .wr(wr), .din(din),
        .rd(rd), .dout(dout), .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
    );

    fifo_flags #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_LEVEL(30), .AE_LEVEL(2)) u_fwft (
        .clk(clk), .rst(rst), .flush(f_flush), .clr_err(f_clr_err), .wr(f_wr), .din(f_din),
        .rd(f_rd), .dout(f_dout), .empty(f_empty), .full(f_full), .almost_empty(f_almost_empty),
        .almost_full(f_almost_full), .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        wr = 1'b1; din = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic pop(output logic [W-1:0] d);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        d = dout;
    endtask

    task automatic test_reset();
        logic [W-1:0] d;
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (count !== 6'd0)     begin n_bad++; $display("FAIL reset_count got %0d exp 0", count); end
        n_cmp++; if (empty !== 1'b1)     begin n_bad++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_cmp++; if (full !== 1'b0)      begin n_bad++; $display("FAIL reset_full got %b exp 0", full); end
        n_cmp++; if (almost_empty !== 1'b1 || almost_full !== 1'b0)
            begin n_bad++; $display("FAIL reset_almost got ae=%b af=%b exp ae=1 af=0", almost_empty, almost_full); end
        n_cmp++; if (dout !== '0)        begin n_bad++; $display("FAIL reset_dout got %h exp 0", dout); end
        n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0)
            begin n_bad++; $display("FAIL reset_err got ov=%b un=%b exp 0 0", overflow, underflow); end
        @(negedge clk); rst = 1'b1;
        tick();
        // Build up state: an underflow, dout loaded, count=5.
        rd = 1'b1; tick(); rd = 1'b0;
        for (int i = 0; i < 5; i++) push(W'(32'h10 + i));
        pop(d);
        push(W'(32'h15));
        n_cmp++; if (count !== 6'd5 || dout !== W'(32'h10) || underflow !== 1'b1)
            begin n_bad++; $display("FAIL pre_reset got cnt=%0d dout=%h un=%b exp 5 10 1", count, dout, underflow); end
        #3 rst = 1'b0;
        #1;
        n_cmp++; if (count !== 6'd0 || empty !== 1'b1 || dout !== '0 || underflow !== 1'b0 || overflow !== 1'b0)
            begin n_bad++; $display("FAIL async_reset got cnt=%0d e=%b dout=%h ov=%b un=%b exp 0 1 0 0 0",
                                    count, empty, dout, overflow, underflow); end
        @(negedge clk); rst = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        logic [W-1:0] d;
        for (int i = 0; i < 32; i++) begin
            push(W'(i));
            if (i == 28) begin
                n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL af_29 got %b exp 0", almost_full); end
            end
            if (i == 29) begin
                n_cmp++; if (almost_full !== 1'b1) begin n_bad++; $display("FAIL af_30 got %b exp 1", almost_full); end
            end
            if (i == 30) begin
                n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL full_31 got %b exp 0", full); end
            end
        end
        n_cmp++; if (full !== 1'b1 || count !== 6'd32)
            begin n_bad++; $display("FAIL fill_full got full=%b cnt=%0d exp 1 32", full, count); end
        for (int i = 0; i < 32; i++) begin
            pop(d);
            n_cmp++; if (d !== W'(i)) begin n_bad++; $display("FAIL drain_data[%0d] got %h exp %h", i, d, i); end
            n_cmp++; if (almost_empty !== ((31 - i) <= 2))
                begin n_bad++; $display("FAIL drain_ae cnt=%0d got %b exp %b", 31 - i, almost_empty, (31 - i) <= 2); end
            n_cmp++; if (count !== 6'(31 - i))
                begin n_bad++; $display("FAIL drain_count got %0d exp %0d", count, 31 - i); end
        end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty got %b exp 1", empty); end
    endtask

    task automatic test_full_boundary();
        logic [W-1:0] d;
        for (int i = 0; i < 32; i++) push(W'(i));
        push(W'(32'hAA));
        n_cmp++; if (count !== 6'd32 || overflow !== 1'b1)
            begin n_bad++; $display("FAIL full_wr got cnt=%0d ov=%b exp 32 1", count, overflow); end
        wr = 1'b1; rd = 1'b1; din = W'(32'hBB);
        tick();
        wr = 1'b0; rd = 1'b0;
        n_cmp++; if (count !== 6'd32 || dout !== W'(0) || full !== 1'b1)
            begin n_bad++; $display("FAIL full_wr_rd got cnt=%0d dout=%h full=%b exp 32 0 1", count, dout, full); end
        for (int i = 1; i < 32; i++) begin
            pop(d);
            n_cmp++; if (d !== W'(i)) begin n_bad++; $display("FAIL full_drain[%0d] got %h exp %h", i, d, i); end
        end
        pop(d);
        n_cmp++; if (d !== W'(32'hBB)) begin n_bad++; $display("FAIL full_last got %h exp bb", d); end
    endtask

    task automatic test_empty_boundary();
        logic [W-1:0] d;
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0)
            begin n_bad++; $display("FAIL clr_err got ov=%b un=%b exp 0 0", overflow, underflow); end
        rd = 1'b1; tick(); rd = 1'b0;
        n_cmp++; if (underflow !== 1'b1 || dout !== W'(32'hBB) || count !== 6'd0)
            begin n_bad++; $display("FAIL empty_rd got un=%b dout=%h cnt=%0d exp 1 bb 0", underflow, dout, count); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        wr = 1'b1; rd = 1'b1; din = W'(32'h55);
        tick();
        wr = 1'b0; rd = 1'b0;
        n_cmp++; if (count !== 6'd1 || underflow !== 1'b1 || dout !== W'(32'hBB))
            begin n_bad++; $display("FAIL empty_wr_rd got cnt=%0d un=%b dout=%h exp 1 1 bb", count, underflow, dout); end
        pop(d);
        n_cmp++; if (d !== W'(32'h55) || empty !== 1'b1)
            begin n_bad++; $display("FAIL empty_pop got %h e=%b exp 55 1", d, empty); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d;
        for (int i = 0; i < 3; i++) push(W'(32'h100 + i));
        for (int i = 0; i < 10; i++) begin
            wr = 1'b1; rd = 1'b1; din = W'(32'h103 + i);
            tick();
            n_cmp++; if (dout !== W'(32'h100 + i) || count !== 6'd3)
                begin n_bad++; $display("FAIL b2b[%0d] got dout=%h cnt=%0d exp %h 3", i, dout, count, 32'h100 + i); end
        end
        wr = 1'b0; rd = 1'b0;
        for (int i = 0; i < 3; i++) pop(d);
        n_cmp++; if (d !== W'(32'h10C) || empty !== 1'b1)
            begin n_bad++; $display("FAIL b2b_tail got %h e=%b exp 10c 1", d, empty); end
    endtask

    task automatic test_wrap();
        logic [W-1:0] d;
        int seq = 0;
        int errs = 0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 20; i++) push(W'(c * 20 + i));
            for (int i = 0; i < 20; i++) begin
                pop(d);
                n_cmp++; if (d !== W'(seq)) begin n_bad++; errs++; $display("FAIL wrap[%0d] got %h exp %h", seq, d, seq); end
                seq++;
            end
        end
        // Raise both error flags, then show set beats clear in the same cycle.
        for (int i = 0; i < 32; i++) push(W'(i));
        push(W'(32'hEE));
        for (int i = 0; i < 32; i++) pop(d);
        rd = 1'b1; tick(); rd = 1'b0;
        n_cmp++; if (overflow !== 1'b1 || underflow !== 1'b1)
            begin n_bad++; $display("FAIL both_err got ov=%b un=%b exp 1 1", overflow, underflow); end
        clr_err = 1'b1; rd = 1'b1; tick(); clr_err = 1'b0; rd = 1'b0;
        n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b1)
            begin n_bad++; $display("FAIL set_wins got ov=%b un=%b exp 0 1", overflow, underflow); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0)
            begin n_bad++; $display("FAIL wrap_clr got ov=%b un=%b exp 0 0", overflow, underflow); end
        for (int i = 0; i < 7; i++) push(W'(32'h70 + i));
        pop(d);
        push(W'(32'h77));
        n_cmp++; if (count !== 6'd7 || dout !== W'(32'h70))
            begin n_bad++; $display("FAIL pre_flush got cnt=%0d dout=%h exp 7 70", count, dout); end
        flush = 1'b1; wr = 1'b1; rd = 1'b1; din = W'(32'h99);
        tick();
        flush = 1'b0; wr = 1'b0; rd = 1'b0;
        n_cmp++; if (count !== 6'd0 || empty !== 1'b1 || dout !== '0 || overflow !== 1'b0 || underflow !== 1'b0)
            begin n_bad++; $display("FAIL flush got cnt=%0d e=%b dout=%h ov=%b un=%b exp 0 1 0 0 0",
                                    count, empty, dout, overflow, underflow); end
        push(W'(32'h42));
        pop(d);
        n_cmp++; if (d !== W'(32'h42)) begin n_bad++; $display("FAIL post_flush got %h exp 42", d); end
    endtask

    task automatic test_fwft();
        n_cmp++; if (f_empty !== 1'b1) begin n_bad++; $display("FAIL fwft_idle got e=%b exp 1", f_empty); end
        f_wr = 1'b1; f_din = W'(32'h11);
        tick();
        n_cmp++; if (f_empty !== 1'b0 || f_dout !== W'(32'h11))
            begin n_bad++; $display("FAIL fwft_first got e=%b dout=%h exp 0 11", f_empty, f_dout); end
        f_din = W'(32'h22);
        tick();
        f_wr = 1'b0;
        n_cmp++; if (f_dout !== W'(32'h11) || f_count !== 6'd2)
            begin n_bad++; $display("FAIL fwft_hold got dout=%h cnt=%0d exp 11 2", f_dout, f_count); end
        f_rd = 1'b1;
        tick();
        f_rd = 1'b0;
        n_cmp++; if (f_dout !== W'(32'h22) || f_count !== 6'd1)
            begin n_bad++; $display("FAIL fwft_adv got dout=%h cnt=%0d exp 22 1", f_dout, f_count); end
        f_rd = 1'b1;
        tick();
        f_rd = 1'b0;
        n_cmp++; if (f_empty !== 1'b1 || f_underflow !== 1'b0)
            begin n_bad++; $display("FAIL fwft_empty got e=%b un=%b exp 1 0", f_empty, f_underflow); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_boundary();
        test_empty_boundary();
        test_back_to_back();
        test_wrap();
        test_fwft();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
